// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl
//   Runtime-configurable control sequencer for a shared-butterfly DIT FFT.
//   It steps one shared butterfly through three phases. LOAD writes n points.
//   CALC runs log2n stages. UNLOAD reads n points. The FFT size n = 2^log2n is
//   chosen when a start is accepted. All outputs are registered.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   en               clock enable; when low every register holds
//   start, mode      request (mode 01 = load+calc, 10 = unload), sampled in IDLE
//   log2n, inv       size select and inverse flag, latched on an accepted start
//   abort            cancels any active operation, with no done pulse
//   state            0 IDLE, 1 LOAD, 2 CALC, 3 UNLOAD
//   rd_en, rd_point  memory read strobe and index
//   wr_en, wr_point  memory write strobe and index
//   stage            current butterfly stage during CALC
//   inv_q            latched inverse flag
//   busy, done, err  activity level, completion pulse, rejected-start pulse
module fft_seq_ctrl #(
  parameter int N_MAX    = 8192,
  parameter int LOG2_MIN = 2,
  parameter int BF_LAT   = 4,
  parameter int ADDR_W   = $clog2(N_MAX),
  parameter int STAGE_W  = $clog2(ADDR_W),
  parameter int LOG2_W   = $clog2(ADDR_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [LOG2_W-1:0]  log2n,
  input  logic               inv,
  input  logic               abort,
  output logic [2:0]         state,
  output logic [ADDR_W-1:0]  rd_point,
  output logic [ADDR_W-1:0]  wr_point,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic               wr_en,
  output logic               inv_q,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // The shared counter must hold both n-1 (LOAD/UNLOAD) and n/2+BF_LAT-1 (CALC).
  localparam int CNT_W = $clog2(N_MAX + BF_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_UNLOAD = 3'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [STAGE_W-1:0] r_stage;
  logic [LOG2_W-1:0]  r_log2n;
  logic               r_inv;
  logic               r_rd_en;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_rd_pt;
  logic [ADDR_W-1:0]  r_wr_pt;
  logic               r_done;
  logic               r_err;

  state_t             w_state_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [STAGE_W-1:0] w_stage_n;
  logic [LOG2_W-1:0]  w_log2n_n;
  logic               w_inv_n;
  logic               w_done_n;
  logic               w_err_n;
  logic               w_rd_en_n;
  logic               w_wr_en_n;
  logic [ADDR_W-1:0]  w_rd_pt_n;
  logic [ADDR_W-1:0]  w_wr_pt_n;

  logic [CNT_W-1:0]   w_n;
  logic [CNT_W-1:0]   w_half;
  logic [CNT_W-1:0]   w_last_pt;
  logic [CNT_W-1:0]   w_last_ph;
  logic               w_legal;
  logic               w_last_stage;

  assign w_n          = CNT_W'(1) << r_log2n;
  assign w_half       = w_n >> 1;
  assign w_last_pt    = w_n - CNT_W'(1);
  assign w_last_ph    = w_half + CNT_W'(BF_LAT - 1);
  assign w_legal      = (log2n >= LOG2_W'(LOG2_MIN)) && (log2n <= LOG2_W'(ADDR_W));
  assign w_last_stage = (LOG2_W'(r_stage) == (r_log2n - LOG2_W'(1)));

  // Next-state and counter sequencing
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_stage_n = r_stage;
    w_log2n_n = r_log2n;
    w_inv_n   = r_inv;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && (mode == 2'b01 || mode == 2'b10)) begin
          if (!w_legal) begin
            w_err_n = 1'b1;
          end else begin
            w_log2n_n = log2n;
            w_inv_n   = inv;
            w_cnt_n   = '0;
            w_stage_n = '0;
            w_state_n = (mode == 2'b01) ? S_LOAD : S_UNLOAD;
          end
        end
      end
      S_LOAD: begin
        if (r_cnt == w_last_pt) begin
          w_state_n = S_CALC;
          w_cnt_n   = '0;
          w_stage_n = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_CALC: begin
        // A stage ends only after its last write-back, so stages never overlap.
        if (r_cnt == w_last_ph) begin
          w_cnt_n = '0;
          if (w_last_stage) begin
            w_state_n = S_IDLE;
            w_stage_n = '0;
            w_done_n  = 1'b1;
          end else begin
            w_stage_n = r_stage + STAGE_W'(1);
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_UNLOAD: begin
        if (r_cnt == w_last_pt) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_done_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_stage_n = '0;
      end
    endcase

    // Abort overrides every transition but leaves IDLE untouched.
    if (abort && r_state != S_IDLE) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
      w_stage_n = '0;
      w_done_n  = 1'b0;
    end
  end

  // Output decode from the next state, so the strobes line up with the indices.
  always_comb begin
    w_rd_en_n = 1'b0;
    w_wr_en_n = 1'b0;
    w_rd_pt_n = r_rd_pt;
    w_wr_pt_n = r_wr_pt;
    case (w_state_n)
      S_LOAD: begin
        w_wr_en_n = 1'b1;
        w_wr_pt_n = ADDR_W'(w_cnt_n);
      end
      S_CALC: begin
        w_rd_en_n = (w_cnt_n < w_half);
        w_wr_en_n = (w_cnt_n >= CNT_W'(BF_LAT));
        if (w_rd_en_n) w_rd_pt_n = ADDR_W'(w_cnt_n);
        if (w_wr_en_n) w_wr_pt_n = ADDR_W'(w_cnt_n - CNT_W'(BF_LAT));
      end
      S_UNLOAD: begin
        w_rd_en_n = 1'b1;
        w_rd_pt_n = ADDR_W'(w_cnt_n);
      end
      default: begin
        w_rd_en_n = 1'b0;
        w_wr_en_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
      r_log2n <= '0;
      r_inv   <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_pt <= '0;
      r_wr_pt <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_stage <= w_stage_n;
      r_log2n <= w_log2n_n;
      r_inv   <= w_inv_n;
      r_rd_en <= w_rd_en_n;
      r_wr_en <= w_wr_en_n;
      r_rd_pt <= w_rd_pt_n;
      r_wr_pt <= w_wr_pt_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end

  assign state    = r_state;
  assign rd_point = r_rd_pt;
  assign wr_point = r_wr_pt;
  assign stage    = r_stage;
  assign rd_en    = r_rd_en;
  assign wr_en    = r_wr_en;
  assign inv_q    = r_inv;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl
//   Scoreboard bench for fft_seq_ctrl with N_MAX=16 and BF_LAT=4. Directed
//   operations push their expected per-cycle beats into a queue. A monitor
//   compares every enabled, active output cycle against that queue.
module tb_fft_seq_ctrl;
  localparam int N_MAX    = 16;
  localparam int LOG2_MIN = 2;
  localparam int BF_LAT   = 4;
  localparam int ADDR_W   = 4;
  localparam int STAGE_W  = 2;
  localparam int LOG2_W   = 3;

  logic               clk = 1'b0;
  logic               rst, en, start, inv, abort;
  logic [1:0]         mode;
  logic [LOG2_W-1:0]  log2n;
  logic [2:0]         state;
  logic [ADDR_W-1:0]  rd_point, wr_point;
  logic [STAGE_W-1:0] stage;
  logic               rd_en, wr_en, inv_q, busy, done, err;

  fft_seq_ctrl #(
    .N_MAX(N_MAX), .LOG2_MIN(LOG2_MIN), .BF_LAT(BF_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .log2n(log2n),
    .inv(inv), .abort(abort), .state(state), .rd_point(rd_point),
    .wr_point(wr_point), .stage(stage), .rd_en(rd_en), .wr_en(wr_en),
    .inv_q(inv_q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       busy;
    logic       rd_en;
    logic [3:0] rd_pt;
    logic       wr_en;
    logic [3:0] wr_pt;
    logic [1:0] stg;
    logic       inv_q;
    logic       done;
    logic       err;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beat_no  = 0;
  logic  model_inv = 1'b0;

  function automatic beat_t mk(input int st, input int bz, input int re, input int rp,
                               input int we, input int wp, input int sg, input logic iv,
                               input int dn, input int er);
    beat_t b;
    b.st = 3'(st); b.busy = 1'(bz); b.rd_en = 1'(re); b.rd_pt = 4'(rp);
    b.wr_en = 1'(we); b.wr_pt = 4'(wp); b.stg = 2'(sg); b.inv_q = iv;
    b.done = 1'(dn); b.err = 1'(er);
    return b;
  endfunction

  // Expected beats of one operation, truncated to 'limit' beats when limit >= 0.
  task automatic gen_op(input logic [1:0] md, input int l2, input logic iv, input int limit);
    beat_t all[$];
    int n;
    n = 1 << l2;
    if (md == 2'b01) begin
      for (int p = 0; p < n; p++) all.push_back(mk(1, 1, 0, 0, 1, p, 0, iv, 0, 0));
      for (int s = 0; s < l2; s++)
        for (int ph = 0; ph < n/2 + BF_LAT; ph++)
          all.push_back(mk(2, 1, int'(ph < n/2), ph, int'(ph >= BF_LAT), ph - BF_LAT, s, iv, 0, 0));
    end else begin
      for (int p = 0; p < n; p++) all.push_back(mk(3, 1, 1, p, 0, 0, 0, iv, 0, 0));
    end
    all.push_back(mk(0, 0, 0, 0, 0, 0, 0, iv, 1, 0));
    for (int k = 0; k < all.size() && (limit < 0 || k < limit); k++) exp_q.push_back(all[k]);
    model_inv = iv;
  endtask

  // Monitor: one beat per enabled cycle with anything active on the outputs.
  always @(negedge clk) begin
    beat_t e;
    logic  ok;
    if (!rst && en && (busy || done || err || rd_en || wr_en)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat%0d unexpected: st=%0d rd_en=%b wr_en=%b done=%b err=%b, required no activity",
                 beat_no, state, rd_en, wr_en, done, err);
      end else begin
        e  = exp_q.pop_front();
        ok = (state === e.st) && (busy === e.busy) && (rd_en === e.rd_en) &&
             (wr_en === e.wr_en) && (inv_q === e.inv_q) && (done === e.done) &&
             (err === e.err) && (!e.rd_en || rd_point === e.rd_pt) &&
             (!e.wr_en || wr_point === e.wr_pt) && (e.st != 3'd2 || stage === e.stg);
        if (!ok) begin
          failures++;
          $display("FAIL beat%0d got st=%0d busy=%b rd=%b/%0d wr=%b/%0d stg=%0d inv=%b done=%b err=%b required st=%0d busy=%b rd=%b/%0d wr=%b/%0d stg=%0d inv=%b done=%b err=%b",
                   beat_no, state, busy, rd_en, rd_point, wr_en, wr_point, stage, inv_q, done, err,
                   e.st, e.busy, e.rd_en, e.rd_pt, e.wr_en, e.wr_pt, e.stg, e.inv_q, e.done, e.err);
        end
      end
      beat_no++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] md, input int l2, input logic iv);
    mode = md; log2n = LOG2_W'(l2); inv = iv; start = 1'b1;
    cyc(1);
    start = 1'b0; mode = 2'b00; inv = 1'b0;
  endtask

  // Counts edges after acceptance until done is visible; bounded.
  task automatic wait_done(inout int n);
    while (!done && n < 400) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_rd_point"}, 32'(rd_point), 0);
    chk({tag, "_wr_point"}, 32'(wr_point), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_inv_q"}, 32'(inv_q), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] snap_rd, snap_wr, snap_st, snap_stg, snap_re, snap_we;
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 2'b00; log2n = '0; inv = 1'b0; abort = 1'b0;
    cyc(2);
    chk_reset("reset");
    rst = 1'b0;
    cyc(1);

    // Load + calc, n = 8: 8 writes, 3 stages of 8 cycles, done 32 edges after accept
    gen_op(2'b01, 3, 1'b0, -1);
    issue(2'b01, 3, 1'b0);
    n = 0; wait_done(n);
    chk("run8_done_latency", 32'(n), 32);
    cyc(1);

    // Illegal sizes: err pulse, stay idle, inv not latched
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, model_inv, 0, 1));
    issue(2'b01, 1, 1'b1);
    chk("err_lo_state", 32'(state), 0);
    chk("err_lo_busy", 32'(busy), 0);
    cyc(1);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, model_inv, 0, 1));
    issue(2'b01, 5, 1'b1);
    chk("err_hi_state", 32'(state), 0);
    chk("err_hi_busy", 32'(busy), 0);
    cyc(1);
    chk("err_cleared", 32'(err), 0);

    // Unload, n = 16, inverse
    gen_op(2'b10, 4, 1'b1, -1);
    issue(2'b10, 4, 1'b1);
    n = 0; wait_done(n);
    chk("unload_done_latency", 32'(n), 16);
    chk("unload_inv_q", 32'(inv_q), 1);
    cyc(1);

    // Abort at stage 1 phase 2 (beat 18), then an immediate full run
    gen_op(2'b01, 3, 1'b0, 19);
    issue(2'b01, 3, 1'b0);
    cyc(18);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_state", 32'(state), 0);
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    gen_op(2'b01, 3, 1'b0, -1);
    issue(2'b01, 3, 1'b0);
    n = 0; wait_done(n);
    chk("post_abort_latency", 32'(n), 32);
    cyc(1);

    // Three-cycle stall mid-CALC
    gen_op(2'b01, 3, 1'b0, -1);
    issue(2'b01, 3, 1'b0);
    cyc(12);
    snap_rd = 32'(rd_point); snap_wr = 32'(wr_point); snap_st = 32'(state);
    snap_stg = 32'(stage); snap_re = 32'(rd_en); snap_we = 32'(wr_en);
    en = 1'b0;
    cyc(3);
    chk("stall_state", 32'(state), snap_st);
    chk("stall_stage", 32'(stage), snap_stg);
    chk("stall_rd_point", 32'(rd_point), snap_rd);
    chk("stall_wr_point", 32'(wr_point), snap_wr);
    chk("stall_rd_en", 32'(rd_en), snap_re);
    chk("stall_wr_en", 32'(wr_en), snap_we);
    en = 1'b1;
    n = 15; wait_done(n);
    chk("stall_done_latency", 32'(n), 35);
    cyc(1);

    // Reset held two cycles mid-CALC, then a normal run
    gen_op(2'b01, 3, 1'b1, 12);
    issue(2'b01, 3, 1'b1);
    cyc(12);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    model_inv = 1'b0;
    chk_reset("midrst");
    gen_op(2'b01, 3, 1'b0, -1);
    issue(2'b01, 3, 1'b0);
    n = 0; wait_done(n);
    chk("post_rst_latency", 32'(n), 32);

    cyc(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
